cordic_sweep_ctrl: RTL and testbench

CORDIC_SWEEP_CTRL -- requirements
Module: cordic_sweep_ctrl

---
 rtl/cordic_sweep_ctrl_if.sv | 30 +++
 rtl/cordic_sweep_ctrl.sv | 122 ++++++++++++
 tb/tb_cordic_sweep_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sweep_ctrl_if.sv
// Sweep controller bus: start/abort request, sweep configuration,
// and the phase increment and status returned to the requester.
interface cordic_sweep_ctrl_if #(
   parameter int PW = 19,
   parameter int DW = 16
);
   logic          start;
   logic          abort;
   logic [PW-1:0] cfg_start;
   logic [PW-1:0] cfg_stop;
   logic [PW-1:0] cfg_step;
   logic [DW-1:0] cfg_dwell;
   logic [PW-1:0] phase_inc;
   logic          busy;
   logic          settled;
   logic          done;
   logic [15:0]   step_idx;

   modport master (
      output start, abort,
      output cfg_start, cfg_stop, cfg_step, cfg_dwell,
      input  phase_inc, busy, settled, done, step_idx
   );

   modport slave (
      input  start, abort,
      input  cfg_start, cfg_stop, cfg_step, cfg_dwell,
      output phase_inc, busy, settled, done, step_idx
   );
endinterface

// File: rtl/cordic_sweep_ctrl.sv
// Frequency sweep controller: steps a CORDIC phase increment from start
// to stop, waiting for the pipeline to settle and dwelling at each point.
module cordic_sweep_ctrl #(
   parameter int PW     = 19,
   parameter int DW     = 16,
   parameter int SETTLE = 17
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   cordic_sweep_ctrl_if.slave    bus
);
   localparam int SW = $clog2(SETTLE + 1);
   localparam int CW = (DW > SW) ? DW : SW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_DWELL,
      ST_DONE
   } state_t;

   state_t        state_q;
   logic [PW-1:0] phase_q;
   logic [PW-1:0] stop_q;
   logic [PW-1:0] step_q;
   logic [DW-1:0] dwell_q;
   logic [15:0]   idx_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          settled_q;
   logic          done_q;
   logic [1:0]    sync_q;

   logic [PW:0]   nxt_d;
   logic          last_d;
   logic [CW-1:0] dwell_ld_d;

   // Widened add so a step past the top of the range is seen, not wrapped.
   always_comb begin
      nxt_d      = {1'b0, phase_q} + {1'b0, step_q};
      last_d     = (step_q == '0) || (nxt_d > {1'b0, stop_q});
      dwell_ld_d = '0;
      if (dwell_q != '0) dwell_ld_d = CW'(dwell_q - 1'b1);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         phase_q   <= '0;
         stop_q    <= '0;
         step_q    <= '0;
         dwell_q   <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         settled_q <= 1'b0;
         done_q    <= 1'b0;
         sync_q    <= '0;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
         if (bus.abort && state_q != ST_IDLE) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            done_q    <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  // Only accept work once reset release has been synchronised.
                  if (bus.start && !bus.abort && sync_q[1]) begin
                     stop_q  <= bus.cfg_stop;
                     step_q  <= bus.cfg_step;
                     dwell_q <= bus.cfg_dwell;
                     phase_q <= bus.cfg_start;
                     idx_q   <= '0;
                     cnt_q   <= CW'(SETTLE - 1);
                     busy_q  <= 1'b1;
                     state_q <= ST_SETTLE;
                  end
               end
               ST_SETTLE: begin
                  if (cnt_q == '0) begin
                     cnt_q     <= dwell_ld_d;
                     settled_q <= 1'b1;
                     state_q   <= ST_DWELL;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               ST_DWELL: begin
                  if (cnt_q == '0) begin
                     settled_q <= 1'b0;
                     if (last_d) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        phase_q <= nxt_d[PW-1:0];
                        if (idx_q != 16'hFFFF) idx_q <= idx_q + 16'd1;
                        cnt_q   <= CW'(SETTLE - 1);
                        state_q <= ST_SETTLE;
                     end
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               ST_DONE: begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.phase_inc = phase_q;
   assign bus.busy      = busy_q;
   assign bus.settled   = settled_q;
   assign bus.done      = done_q;
   assign bus.step_idx  = idx_q;
endmodule

// File: tb/tb_cordic_sweep_ctrl.sv
// Bench for cordic_sweep_ctrl: scoreboard of expected sweep points
// checked as each settled window opens and closes.
module tb_cordic_sweep_ctrl;
   logic sys_clk;
   logic rst_n;

   cordic_sweep_ctrl_if #(.PW(19), .DW(16)) bus ();

   cordic_sweep_ctrl #(.PW(19), .DW(16), .SETTLE(17)) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [18:0] ph;
      logic [15:0] idx;
      int          dw;
   } pt_t;

   pt_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  done_cnt = 0;
   int  run_len = 0;
   int  cur_dw = 0;
   bit  set_prev = 1'b0;
   bit  skip_len = 1'b0;
   pt_t e;

   // Scoreboard monitor: pop a point on each settled rise, check its length.
   always begin
      @(posedge sys_clk);
      #1;
      if (!rst_n) begin
         set_prev = 1'b0;
         run_len  = 0;
      end else begin
         if (bus.settled && !set_prev) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL point_unexpected: got ph=%0d idx=%0d, required none",
                        bus.phase_inc, bus.step_idx);
            end else begin
               e = exp_q.pop_front();
               cur_dw  = e.dw;
               run_len = 0;
               if (bus.phase_inc !== e.ph || bus.step_idx !== e.idx) begin
                  bad++;
                  $display("FAIL point: got ph=%0d idx=%0d, required ph=%0d idx=%0d",
                           bus.phase_inc, bus.step_idx, e.ph, e.idx);
               end
            end
         end
         if (bus.settled) run_len++;
         if (!bus.settled && set_prev && !skip_len) begin
            total++;
            if (run_len !== cur_dw) begin
               bad++;
               $display("FAIL dwell_len: got %0d, required %0d", run_len, cur_dw);
            end
         end
         if (bus.done) done_cnt++;
         set_prev = bus.settled;
      end
   end

   task automatic kick(input logic [18:0] s, input logic [18:0] stp,
                       input logic [18:0] st, input logic [15:0] d);
      logic [19:0] p;
      logic [19:0] nx;
      logic [15:0] i;
      pt_t         q;
      p = {1'b0, s};
      i = '0;
      for (int k = 0; k < 1000; k++) begin
         q.ph  = p[18:0];
         q.idx = i;
         q.dw  = (d == 0) ? 1 : int'(d);
         exp_q.push_back(q);
         if (st == 0) break;
         nx = p + {1'b0, st};
         if (nx > {1'b0, stp}) break;
         p = nx;
         i = i + 16'd1;
      end
      @(negedge sys_clk);
      bus.cfg_start = s;
      bus.cfg_stop  = stp;
      bus.cfg_step  = st;
      bus.cfg_dwell = d;
      bus.start     = 1'b1;
      @(negedge sys_clk);
      bus.start     = 1'b0;
      bus.cfg_start = 19'($urandom);
      bus.cfg_stop  = 19'($urandom);
      bus.cfg_step  = 19'($urandom);
      bus.cfg_dwell = 16'($urandom);
   endtask

   // Returns edges from the start-sampling edge to done, or -1 on timeout.
   task automatic sweep(input logic [18:0] s, input logic [18:0] stp,
                        input logic [18:0] st, input logic [15:0] d,
                        output int lat);
      kick(s, stp, st, d);
      lat = 1;
      for (int k = 0; k < 5000; k++) begin
         @(posedge sys_clk);
         #1;
         lat++;
         if (bus.done) return;
      end
      lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.cfg_start = '0;
      bus.cfg_stop  = '0;
      bus.cfg_step  = '0;
      bus.cfg_dwell = '0;
      #23;
      total += 5;
      if (bus.phase_inc !== 19'd0) begin
         bad++; $display("FAIL rst_phase: got %0d, required 0", bus.phase_inc);
      end
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL rst_busy: got %b, required 0", bus.busy);
      end
      if (bus.settled !== 1'b0) begin
         bad++; $display("FAIL rst_settled: got %b, required 0", bus.settled);
      end
      if (bus.done !== 1'b0) begin
         bad++; $display("FAIL rst_done: got %b, required 0", bus.done);
      end
      if (bus.step_idx !== 16'd0) begin
         bad++; $display("FAIL rst_idx: got %0d, required 0", bus.step_idx);
      end
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (4) @(posedge sys_clk);
   endtask

   task automatic test_basic();
      int lat;
      sweep(19'd100, 19'd300, 19'd100, 16'd4, lat);
      total += 4;
      if (lat !== 64) begin
         bad++; $display("FAIL basic_lat: got %0d, required 64", lat);
      end
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL basic_busy_done: got %b, required 1", bus.busy);
      end
      if (bus.phase_inc !== 19'd300 || bus.step_idx !== 16'd2) begin
         bad++; $display("FAIL basic_end: got ph=%0d idx=%0d, required 300 2",
                         bus.phase_inc, bus.step_idx);
      end
      if (exp_q.size() !== 0) begin
         bad++; $display("FAIL basic_left: got %0d, required 0", exp_q.size());
      end
      @(posedge sys_clk);
      #1;
      total += 2;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL basic_idle: got done=%b busy=%b, required 0 0",
                         bus.done, bus.busy);
      end
      repeat (10) @(posedge sys_clk);
      #1;
      if (bus.phase_inc !== 19'd300) begin
         bad++; $display("FAIL basic_hold: got %0d, required 300", bus.phase_inc);
      end
   endtask

   task automatic test_nonaligned();
      int lat;
      sweep(19'd0, 19'd250, 19'd100, 16'd1, lat);
      total += 3;
      if (lat !== 55) begin
         bad++; $display("FAIL nonal_lat: got %0d, required 55", lat);
      end
      if (bus.phase_inc !== 19'd200 || bus.step_idx !== 16'd2) begin
         bad++; $display("FAIL nonal_end: got ph=%0d idx=%0d, required 200 2",
                         bus.phase_inc, bus.step_idx);
      end
      if (exp_q.size() !== 0) begin
         bad++; $display("FAIL nonal_left: got %0d, required 0", exp_q.size());
      end
      repeat (2) @(posedge sys_clk);
   endtask

   task automatic test_wrap();
      int lat;
      sweep(19'd524278, 19'd524287, 19'd8, 16'd2, lat);
      total += 2;
      if (lat !== 39) begin
         bad++; $display("FAIL wrap_lat: got %0d, required 39", lat);
      end
      if (bus.phase_inc !== 19'd524286 || bus.step_idx !== 16'd1) begin
         bad++; $display("FAIL wrap_end: got ph=%0d idx=%0d, required 524286 1",
                         bus.phase_inc, bus.step_idx);
      end
      repeat (2) @(posedge sys_clk);
   endtask

   task automatic test_degenerate();
      int lat;
      sweep(19'd1234, 19'd5000, 19'd0, 16'd3, lat);
      total += 2;
      if (lat !== 21) begin
         bad++; $display("FAIL step0_lat: got %0d, required 21", lat);
      end
      if (bus.phase_inc !== 19'd1234 || bus.step_idx !== 16'd0) begin
         bad++; $display("FAIL step0_end: got ph=%0d idx=%0d, required 1234 0",
                         bus.phase_inc, bus.step_idx);
      end
      repeat (2) @(posedge sys_clk);
      sweep(19'd500, 19'd100, 19'd50, 16'd2, lat);
      total += 2;
      if (lat !== 20) begin
         bad++; $display("FAIL inv_lat: got %0d, required 20", lat);
      end
      if (bus.phase_inc !== 19'd500) begin
         bad++; $display("FAIL inv_end: got %0d, required 500", bus.phase_inc);
      end
      repeat (2) @(posedge sys_clk);
      sweep(19'd700, 19'd700, 19'd100, 16'd0, lat);
      total += 2;
      if (lat !== 19) begin
         bad++; $display("FAIL dw0_lat: got %0d, required 19", lat);
      end
      if (bus.phase_inc !== 19'd700) begin
         bad++; $display("FAIL dw0_end: got %0d, required 700", bus.phase_inc);
      end
      repeat (2) @(posedge sys_clk);
   endtask

   task automatic test_abort();
      int  d0;
      bit  hit;
      hit = 1'b0;
      kick(19'd100, 19'd300, 19'd100, 16'd4);
      for (int k = 0; k < 200; k++) begin
         @(posedge sys_clk);
         #1;
         if (bus.settled && bus.step_idx == 16'd1) begin
            hit = 1'b1;
            break;
         end
      end
      total++;
      if (!hit) begin
         bad++; $display("FAIL abort_reach: got timeout, required second dwell");
      end
      d0 = done_cnt;
      skip_len = 1'b1;
      @(negedge sys_clk);
      bus.abort = 1'b1;
      @(posedge sys_clk);
      #1;
      total += 3;
      if (bus.busy !== 1'b0 || bus.settled !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL abort_stat: got busy=%b set=%b done=%b, required 0 0 0",
                         bus.busy, bus.settled, bus.done);
      end
      if (bus.phase_inc !== 19'd200) begin
         bad++; $display("FAIL abort_ph: got %0d, required 200", bus.phase_inc);
      end
      if (bus.step_idx !== 16'd1) begin
         bad++; $display("FAIL abort_idx: got %0d, required 1", bus.step_idx);
      end
      @(negedge sys_clk);
      bus.abort = 1'b0;
      skip_len = 1'b0;
      exp_q.delete();
      repeat (80) @(posedge sys_clk);
      #1;
      total++;
      if (done_cnt !== d0) begin
         bad++; $display("FAIL abort_done: got %0d pulses, required %0d", done_cnt, d0);
      end
      @(negedge sys_clk);
      bus.cfg_start = 19'd9999;
      bus.cfg_stop  = 19'd9999;
      bus.cfg_dwell = 16'd1;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      total += 2;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL sa_busy: got %b, required 0", bus.busy);
      end
      if (bus.phase_inc !== 19'd200) begin
         bad++; $display("FAIL sa_ph: got %0d, required 200", bus.phase_inc);
      end
   endtask

   task automatic test_reset_retrigger();
      int  lat;
      int  d0;
      bit  hit;
      kick(19'd100, 19'd300, 19'd100, 16'd4);
      repeat (5) @(posedge sys_clk);
      #3;
      rst_n = 1'b0;
      #1;
      total += 2;
      if (bus.busy !== 1'b0 || bus.settled !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL arst_stat: got busy=%b set=%b done=%b, required 0 0 0",
                         bus.busy, bus.settled, bus.done);
      end
      if (bus.phase_inc !== 19'd0 || bus.step_idx !== 16'd0) begin
         bad++; $display("FAIL arst_regs: got ph=%0d idx=%0d, required 0 0",
                         bus.phase_inc, bus.step_idx);
      end
      exp_q.delete();
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (3) @(posedge sys_clk);
      d0 = done_cnt;
      kick(19'd1000, 19'd1000, 19'd0, 16'd3);
      repeat (3) @(negedge sys_clk);
      bus.cfg_start = 19'd7;
      bus.cfg_stop  = 19'h7FFFF;
      bus.cfg_step  = 19'd1;
      bus.cfg_dwell = 16'd9;
      bus.start = 1'b1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge sys_clk);
         #1;
         if (bus.done) begin
            hit = 1'b1;
            break;
         end
      end
      total += 3;
      if (!hit) begin
         bad++; $display("FAIL busy_start_done: got timeout, required done");
      end
      if (bus.phase_inc !== 19'd1000 || bus.step_idx !== 16'd0) begin
         bad++; $display("FAIL busy_start_end: got ph=%0d idx=%0d, required 1000 0",
                         bus.phase_inc, bus.step_idx);
      end
      if (exp_q.size() !== 0) begin
         bad++; $display("FAIL busy_start_left: got %0d, required 0", exp_q.size());
      end
      repeat (20) @(posedge sys_clk);
      #1;
      total++;
      if (bus.busy !== 1'b0 || done_cnt !== d0 + 1) begin
         bad++; $display("FAIL busy_start_idle: got busy=%b done=%0d, required 0 %0d",
                         bus.busy, done_cnt, d0 + 1);
      end
      sweep(19'd300, 19'd500, 19'd100, 16'd2, lat);
      total += 2;
      if (lat !== 58) begin
         bad++; $display("FAIL restart_lat: got %0d, required 58", lat);
      end
      if (bus.phase_inc !== 19'd500 || bus.step_idx !== 16'd2) begin
         bad++; $display("FAIL restart_end: got ph=%0d idx=%0d, required 500 2",
                         bus.phase_inc, bus.step_idx);
      end
      repeat (2) @(posedge sys_clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_nonaligned();
      test_wrap();
      test_degenerate();
      test_abort();
      test_reset_retrigger();
      repeat (5) @(posedge sys_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
